// File: rtl/alu_pkg.sv
// Shared constants, opcode map, FSM state encoding and the single-cycle ALU function
// for the execute stage.
package alu_pkg;

   localparam int DATA_W = 16;
   localparam int ADDR_W = 5;
   localparam int OP_W   = 4;

   localparam logic [OP_W-1:0] OP_ADD   = 4'd0;
   localparam logic [OP_W-1:0] OP_SUB   = 4'd1;
   localparam logic [OP_W-1:0] OP_AND   = 4'd2;
   localparam logic [OP_W-1:0] OP_OR    = 4'd3;
   localparam logic [OP_W-1:0] OP_XOR   = 4'd4;
   localparam logic [OP_W-1:0] OP_NOT   = 4'd5;
   localparam logic [OP_W-1:0] OP_SHL   = 4'd6;
   localparam logic [OP_W-1:0] OP_SHR   = 4'd7;
   localparam logic [OP_W-1:0] OP_SLT   = 4'd8;
   localparam logic [OP_W-1:0] OP_MUL   = 4'd9;
   localparam logic [OP_W-1:0] OP_PASSB = 4'd10;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_MUL  = 1'b1
   } stateT;

   // writes is set only for ops that complete in one cycle; MUL and NOPs leave it clear.
   typedef struct packed {
      logic [DATA_W-1:0] result;
      logic              carry;
      logic              writes;
   } aluOutT;

   // Shifts run on a widened word so the bit falling off the end lands in the carry slot;
   // a shift of zero therefore naturally yields carry 0.
   function automatic aluOutT aluCompute(input logic [OP_W-1:0] op,
                                         input logic [DATA_W-1:0] a,
                                         input logic [DATA_W-1:0] b);
      aluOutT          r;
      logic [DATA_W:0] wide;
      logic [3:0]      amt;
      r    = '0;
      wide = '0;
      amt  = b[3:0];
      case (op)
         OP_ADD: begin
            wide     = {1'b0, a} + {1'b0, b};
            r.result = wide[DATA_W-1:0];
            r.carry  = wide[DATA_W];
            r.writes = 1'b1;
         end
         OP_SUB: begin
            wide     = {1'b0, a} - {1'b0, b};
            r.result = wide[DATA_W-1:0];
            r.carry  = wide[DATA_W];
            r.writes = 1'b1;
         end
         OP_AND: begin
            r.result = a & b;
            r.writes = 1'b1;
         end
         OP_OR: begin
            r.result = a | b;
            r.writes = 1'b1;
         end
         OP_XOR: begin
            r.result = a ^ b;
            r.writes = 1'b1;
         end
         OP_NOT: begin
            r.result = ~a;
            r.writes = 1'b1;
         end
         OP_SHL: begin
            wide     = {1'b0, a} << amt;
            r.result = wide[DATA_W-1:0];
            r.carry  = wide[DATA_W];
            r.writes = 1'b1;
         end
         OP_SHR: begin
            wide     = {a, 1'b0} >> amt;
            r.result = wide[DATA_W:1];
            r.carry  = wide[0];
            r.writes = 1'b1;
         end
         OP_SLT: begin
            r.result = {{(DATA_W-1){1'b0}}, ($signed(a) < $signed(b))};
            r.writes = 1'b1;
         end
         OP_PASSB: begin
            r.result = b;
            r.writes = 1'b1;
         end
         default: r = '0;
      endcase
      return r;
   endfunction

endpackage

// File: rtl/seq_multiplier.sv
// Iterative shift-add multiplier: one partial product per clock, DATA_W iterations.
// done/product are combinational so the final iteration's sum is available on the
// same edge that completes it.
module seq_multiplier
   import alu_pkg::*;
(
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic [DATA_W-1:0] a,
   input  logic [DATA_W-1:0] b,
   output logic              done,
   output logic [DATA_W-1:0] product
);

   localparam int CNT_W = $clog2(DATA_W);

   logic [DATA_W-1:0] mcand;
   logic [DATA_W-1:0] mplier;
   logic [DATA_W-1:0] acc;
   logic [DATA_W-1:0] accNext;
   logic [CNT_W-1:0]  count;
   logic              running;

   // Accumulator value after the current iteration's conditional add.
   always_comb begin
      accNext = mplier[0] ? (acc + mcand) : acc;
   end

   assign done    = running && (count == CNT_W'(DATA_W - 1));
   assign product = accNext;

   // Latch operands on start, then shift multiplicand left / multiplier right each cycle.
   always_ff @(posedge clk) begin
      if (rst) begin
         mcand   <= '0;
         mplier  <= '0;
         acc     <= '0;
         count   <= '0;
         running <= 1'b0;
      end else if (start) begin
         mcand   <= a;
         mplier  <= b;
         acc     <= '0;
         count   <= '0;
         running <= 1'b1;
      end else if (running) begin
         acc    <= accNext;
         mcand  <= mcand << 1;
         mplier <= mplier >> 1;
         count  <= count + 1'b1;
         if (count == CNT_W'(DATA_W - 1)) begin
            running <= 1'b0;
         end
      end
   end

endmodule

// File: rtl/alu_execute_stage.sv
// Execute stage: single-cycle ALU ops write back one cycle after accept; MUL holds the
// stage for DATA_W cycles while the sequential multiplier iterates.
module alu_execute_stage
   import alu_pkg::*;
(
   input  logic              clk,
   input  logic              rst,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [OP_W-1:0]   opcode,
   input  logic [DATA_W-1:0] read_dataA,
   input  logic [DATA_W-1:0] read_dataB,
   input  logic [ADDR_W-1:0] dest_add,
   output logic [ADDR_W-1:0] write_addC,
   output logic [DATA_W-1:0] write_dataC,
   output logic              enable_C,
   output logic              flag_zero,
   output logic              flag_carry,
   output logic              busy
);

   stateT             state;
   stateT             stateNext;
   aluOutT            aluOut;
   logic              accept;
   logic              mulStart;
   logic              mulDone;
   logic [DATA_W-1:0] mulProduct;
   logic [ADDR_W-1:0] mulDest;
   logic              enableNext;
   logic [ADDR_W-1:0] addrNext;
   logic [DATA_W-1:0] dataNext;
   logic              zeroNext;
   logic              carryNext;

   assign in_ready = (state == ST_IDLE) && !rst;
   assign busy     = (state == ST_MUL);
   assign accept   = in_valid && in_ready;
   assign aluOut   = aluCompute(opcode, read_dataA, read_dataB);

   seq_multiplier uMul (
      .clk     (clk),
      .rst     (rst),
      .start   (mulStart),
      .a       (read_dataA),
      .b       (read_dataB),
      .done    (mulDone),
      .product (mulProduct)
   );

   // Next state and next writeback values; outputs hold unless a result is produced.
   always_comb begin
      stateNext  = state;
      mulStart   = 1'b0;
      enableNext = 1'b0;
      addrNext   = write_addC;
      dataNext   = write_dataC;
      zeroNext   = flag_zero;
      carryNext  = flag_carry;
      case (state)
         ST_IDLE: begin
            if (accept && (opcode == OP_MUL)) begin
               mulStart  = 1'b1;
               stateNext = ST_MUL;
            end else if (accept && aluOut.writes) begin
               enableNext = 1'b1;
               addrNext   = dest_add;
               dataNext   = aluOut.result;
               zeroNext   = (aluOut.result == '0);
               carryNext  = aluOut.carry;
            end
         end
         ST_MUL: begin
            if (mulDone) begin
               stateNext  = ST_IDLE;
               enableNext = 1'b1;
               addrNext   = mulDest;
               dataNext   = mulProduct;
               zeroNext   = (mulProduct == '0);
               carryNext  = 1'b0;
            end
         end
         default: stateNext = ST_IDLE;
      endcase
   end

   // State, registered writeback port/flags and the latched MUL destination.
   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= ST_IDLE;
         enable_C    <= 1'b0;
         write_addC  <= '0;
         write_dataC <= '0;
         flag_zero   <= 1'b0;
         flag_carry  <= 1'b0;
         mulDest     <= '0;
      end else begin
         state       <= stateNext;
         enable_C    <= enableNext;
         write_addC  <= addrNext;
         write_dataC <= dataNext;
         flag_zero   <= zeroNext;
         flag_carry  <= carryNext;
         if (mulStart) begin
            mulDest <= dest_add;
         end
      end
   end

endmodule

// File: tb/tb_alu_execute_stage.sv
// Self-checking bench for alu_execute_stage: a cycle-level reference model checked every
// cycle, plus directed vectors with hand-computed literal results.
module tb_alu_execute_stage;
   import alu_pkg::*;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [3:0]  opcode = '0;
   logic [15:0] read_dataA = '0;
   logic [15:0] read_dataB = '0;
   logic [4:0]  dest_add = '0;
   logic [4:0]  write_addC;
   logic [15:0] write_dataC;
   logic        enable_C;
   logic        flag_zero;
   logic        flag_carry;
   logic        busy;

   int checkCount = 0;
   int passCount  = 0;

   logic        expEn = 1'b0;
   logic [4:0]  expAddr = '0;
   logic [15:0] expData = '0;
   logic        expZ = 1'b0;
   logic        expC = 1'b0;
   int          mulLeft = 0;
   logic [15:0] mulProd = '0;
   logic [4:0]  mulDest = '0;

   alu_execute_stage dut (
      .clk         (clk),
      .rst         (rst),
      .in_valid    (in_valid),
      .in_ready    (in_ready),
      .opcode      (opcode),
      .read_dataA  (read_dataA),
      .read_dataB  (read_dataB),
      .dest_add    (dest_add),
      .write_addC  (write_addC),
      .write_dataC (write_dataC),
      .enable_C    (enable_C),
      .flag_zero   (flag_zero),
      .flag_carry  (flag_carry),
      .busy        (busy)
   );

   always #5 clk = ~clk;

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      checkCount++;
      if (actual === expected) passCount++;
      else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
   endtask

   // Drive one cycle of inputs, let the edge happen, return just after it.
   task automatic applyStimulus(input logic v, input logic [3:0] op, input logic [15:0] a,
                                input logic [15:0] b, input logic [4:0] d);
      in_valid   = v;
      opcode     = op;
      read_dataA = a;
      read_dataB = b;
      dest_add   = d;
      @(posedge clk);
      #1;
   endtask

   // Reference model: given inputs that the next edge will sample, predict outputs after it.
   task automatic modelStep();
      int     ua, ub, n, r, c, sa, sb;
      longint p;
      logic [63:0] pv;
      ua = int'(read_dataA);
      ub = int'(read_dataB);
      n  = ub % 16;
      r  = 0;
      c  = 0;
      if (rst) begin
         expEn = 0; expAddr = '0; expData = '0; expZ = 0; expC = 0; mulLeft = 0;
      end else if (mulLeft > 0) begin
         mulLeft--;
         expEn = (mulLeft == 0);
         if (mulLeft == 0) begin
            expAddr = mulDest;
            expData = mulProd;
            expZ    = (mulProd == 0);
            expC    = 1'b0;
         end
      end else begin
         expEn = 1'b0;
         if (in_valid && opcode == 4'd9) begin
            p       = longint'(ua) * longint'(ub);
            pv      = 64'(p);
            mulProd = pv[15:0];
            mulDest = dest_add;
            mulLeft = 16;
         end else if (in_valid && opcode <= 4'd10) begin
            sa = (ua >= 32768) ? ua - 65536 : ua;
            sb = (ub >= 32768) ? ub - 65536 : ub;
            case (opcode)
               4'd0: begin r = (ua + ub) % 65536; c = (ua + ub >= 65536) ? 1 : 0; end
               4'd1: begin r = (ua - ub + 65536) % 65536; c = (ua < ub) ? 1 : 0; end
               4'd2: r = ua & ub;
               4'd3: r = ua | ub;
               4'd4: r = ua ^ ub;
               4'd5: r = 65535 - ua;
               4'd6: begin r = (ua * (1 << n)) % 65536; c = (n != 0) ? ((ua * (1 << n)) >> 16) & 1 : 0; end
               4'd7: begin r = ua / (1 << n); c = (n != 0) ? (ua >> (n - 1)) & 1 : 0; end
               4'd8: r = (sa < sb) ? 1 : 0;
               default: r = ub;
            endcase
            expEn   = 1'b1;
            expAddr = dest_add;
            expData = 16'(r);
            expZ    = (r == 0);
            expC    = c[0];
         end
      end
   endtask

   // Compare process: every negedge check DUT against the model, then advance the model.
   initial begin
      @(posedge clk);
      forever begin
         @(negedge clk);
         checkOutput("enable_C", enable_C, expEn);
         checkOutput("write_addC", write_addC, expAddr);
         checkOutput("write_dataC", write_dataC, expData);
         checkOutput("flag_zero", flag_zero, expZ);
         checkOutput("flag_carry", flag_carry, expC);
         checkOutput("in_ready", in_ready, (!rst && mulLeft == 0));
         checkOutput("busy", busy, (mulLeft > 0));
         modelStep();
      end
   end

   // Directed sequence with literal expectations.
   initial begin
      int cycles;
      logic found;
      repeat (3) @(posedge clk);
      #1;
      checkOutput("rst_enable", enable_C, 0);
      checkOutput("rst_data", write_dataC, 0);
      checkOutput("rst_ready", in_ready, 0);
      checkOutput("rst_busy", busy, 0);
      rst = 1'b0;
      #1;
      checkOutput("ready_after_rst", in_ready, 1);

      applyStimulus(1, 4'd0, 16'h7FFF, 16'h0001, 5'd3);
      checkOutput("add1_en", enable_C, 1);
      checkOutput("add1_addr", write_addC, 3);
      checkOutput("add1_data", write_dataC, 16'h8000);
      checkOutput("add1_zero", flag_zero, 0);
      checkOutput("add1_carry", flag_carry, 0);
      applyStimulus(0, 4'd0, 16'h0000, 16'h0000, 5'd0);
      checkOutput("add1_en_drop", enable_C, 0);

      applyStimulus(1, 4'd0, 16'hFFFF, 16'h0001, 5'd4);
      checkOutput("add2_data", write_dataC, 16'h0000);
      checkOutput("add2_zc", {flag_zero, flag_carry}, 2'b11);
      applyStimulus(1, 4'd1, 16'h0003, 16'h0005, 5'd5);
      checkOutput("sub_en", enable_C, 1);
      checkOutput("sub_data", write_dataC, 16'hFFFE);
      checkOutput("sub_zc", {flag_zero, flag_carry}, 2'b01);

      applyStimulus(1, 4'd6, 16'h8001, 16'h0011, 5'd1);
      checkOutput("shl_data", write_dataC, 16'h0002);
      checkOutput("shl_carry", flag_carry, 1);
      applyStimulus(1, 4'd7, 16'h0001, 16'h0000, 5'd2);
      checkOutput("shr0_data", write_dataC, 16'h0001);
      checkOutput("shr0_carry", flag_carry, 0);
      applyStimulus(1, 4'd7, 16'h0003, 16'h0001, 5'd2);
      checkOutput("shr1_carry", flag_carry, 1);
      applyStimulus(1, 4'd7, 16'h8000, 16'h000F, 5'd2);
      checkOutput("shr15_data", write_dataC, 16'h0001);

      applyStimulus(1, 4'd2, 16'hF0F0, 16'hFF00, 5'd8);
      checkOutput("and_data", write_dataC, 16'hF000);
      applyStimulus(1, 4'd3, 16'hF0F0, 16'h0F00, 5'd8);
      applyStimulus(1, 4'd4, 16'hAAAA, 16'hFFFF, 5'd8);
      checkOutput("xor_data", write_dataC, 16'h5555);
      applyStimulus(1, 4'd5, 16'h00FF, 16'h1234, 5'd0);
      checkOutput("not_data", write_dataC, 16'hFF00);
      applyStimulus(1, 4'd8, 16'h8000, 16'h0001, 5'd9);
      checkOutput("slt_true", write_dataC, 16'h0001);
      applyStimulus(1, 4'd8, 16'h0001, 16'h8000, 5'd9);
      checkOutput("slt_false_zero", flag_zero, 1);
      applyStimulus(1, 4'd10, 16'h1111, 16'h1234, 5'd10);
      checkOutput("passb_data", write_dataC, 16'h1234);

      applyStimulus(1, 4'd9, 16'h0123, 16'h0045, 5'd7);
      checkOutput("mul_busy", busy, 1);
      checkOutput("mul_ready", in_ready, 0);
      in_valid = 1'b1; opcode = 4'd0; read_dataA = 16'h0001; read_dataB = 16'h0001; dest_add = 5'd9;
      cycles = 0;
      found  = 1'b0;
      for (int i = 1; i <= 40 && !found; i++) begin
         @(posedge clk);
         #1;
         if (enable_C === 1'b1) begin
            found  = 1'b1;
            cycles = i;
         end
      end
      checkOutput("mul_latency", cycles, 16);
      checkOutput("mul_data", write_dataC, 16'h4E6F);
      checkOutput("mul_addr", write_addC, 7);
      checkOutput("mul_ready_after", in_ready, 1);
      @(posedge clk);
      #1;
      checkOutput("held_add_data", write_dataC, 16'h0002);
      checkOutput("held_add_addr", write_addC, 9);

      applyStimulus(1, 4'd9, 16'h0005, 16'h0006, 5'd2);
      repeat (7) applyStimulus(0, 4'd0, 16'h0000, 16'h0000, 5'd0);
      rst = 1'b1;
      applyStimulus(0, 4'd0, 16'h0000, 16'h0000, 5'd0);
      checkOutput("abort_data", write_dataC, 0);
      checkOutput("abort_addr", write_addC, 0);
      checkOutput("abort_busy", busy, 0);
      checkOutput("abort_en", enable_C, 0);
      applyStimulus(0, 4'd0, 16'h0000, 16'h0000, 5'd0);
      rst = 1'b0;
      #1;
      checkOutput("abort_ready", in_ready, 1);
      repeat (20) applyStimulus(0, 4'd0, 16'h0000, 16'h0000, 5'd0);

      applyStimulus(1, 4'd0, 16'h0002, 16'h0003, 5'd6);
      checkOutput("pre_nop_data", write_dataC, 16'h0005);
      applyStimulus(1, 4'd15, 16'h0009, 16'h0009, 5'd1);
      checkOutput("nop_en", enable_C, 0);
      checkOutput("nop_data", write_dataC, 16'h0005);
      checkOutput("nop_addr", write_addC, 6);
      checkOutput("nop_zero", flag_zero, 0);

      repeat (3) applyStimulus(0, 4'd0, 16'h0000, 16'h0000, 5'd0);
      $display("%0d/%0d checks passed", passCount, checkCount);
      $finish;
   end

endmodule
